// File: rtl/adder_serial_param.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock through a single carry
// chain, start/done handshake, result/carry/overflow held until the next completion.
module adder_serial_param #(
  parameter int unsigned WIDTH = 381,
  parameter int unsigned CHUNK = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int unsigned PW     = NCHUNK * CHUNK;
  // Number of meaningful bits in the top chunk (1..CHUNK); the rest is zero padding.
  localparam int unsigned TOP    = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    a_q, a_d;
  logic [PW-1:0]    b_q, b_d;
  logic [PW-1:0]    part_q, part_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK:0]   sum;
  logic [PW-1:0]    sum_ext;
  logic             last;

  always_comb begin
    sum     = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
    sum_ext = '0;
    sum_ext[CHUNK-1:0] = sum[CHUNK-1:0];
    last    = (cnt_q == CW'(NCHUNK - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d = '0;
          a_d[WIDTH-1:0] = A;
          b_d = '0;
          b_d[WIDTH-1:0] = sub ? ~B : B;
          c_d     = sub | cin;
          cnt_d   = '0;
          part_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        c_d    = sum[CHUNK];
        // Sum chunks enter from the top so chunk 0 ends up at the bottom after NCHUNK shifts.
        part_d = (part_q >> CHUNK) | (sum_ext << (PW - CHUNK));
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          s_d     = part_d[WIDTH-1:0];
          carry_d = sum[TOP];
          // Carry into bit WIDTH-1 is recovered from its sum bit and operand bits.
          ovf_d   = sum[TOP] ^ sum[TOP-1] ^ a_q[TOP-1] ^ b_q[TOP-1];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S        = s_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_adder_serial_param.sv
// Scoreboard bench for adder_serial_param over several WIDTH/CHUNK pairs: directed corner cases,
// ignored starts, held start, mid-run reset, then randomized operations against a wide-math model.
module tb_adder_serial_param;

  localparam int NCFG = 13;

  function automatic int unsigned cfg_w(input int i);
    case (i)
      0, 2, 3, 12: return 381;
      1:           return 8;
      4, 5, 6, 7:  return 64;
      default:     return 33;
    endcase
  endfunction

  function automatic int unsigned cfg_c(input int i);
    case (i)
      0:       return 32;
      1:       return 3;
      2:       return 7;
      3:       return 381;
      4:       return 1;
      5:       return 7;
      6:       return 32;
      7:       return 64;
      8:       return 1;
      9:       return 7;
      10:      return 32;
      11:      return 33;
      default: return 1;
    endcase
  endfunction

  logic clk;
  int   total = 0;
  int   bad   = 0;
  int   n_fin = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input int cfg, input string nm, input logic [511:0] act,
                              input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cfg%0d %s: got %0h expected %0h", cfg, nm, act, exp);
    end
  endfunction

  for (genvar gi = 0; gi < NCFG; gi++) begin : g
    localparam int unsigned W    = cfg_w(gi);
    localparam int unsigned C    = cfg_c(gi);
    localparam int unsigned N    = (W + C - 1) / C;
    localparam int unsigned NOPS = (40000 / (N + 2) > 1500) ? 1500 : 40000 / (N + 2);

    logic         rst_n, start, sub, cin, carry, overflow, busy, done;
    logic [W-1:0] a, b, s;
    logic [W-1:0] q_s[$];
    logic         q_c[$];
    logic         q_v[$];
    int           q_t[$];
    int           cyc = 0;
    logic         prev_done = 1'b0;

    adder_serial_param #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk      (clk),
      .reset    (rst_n),
      .start    (start),
      .sub      (sub),
      .cin      (cin),
      .A        (a),
      .B        (b),
      .S        (s),
      .carry    (carry),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain wide arithmetic; signed overflow from a one-bit sign extension.
    function automatic void push(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb,
                                 input logic ci, input int t);
      logic [W:0] u;
      logic [W:0] sg;
      if (sb) begin
        sg = {x[W-1], x} - {y[W-1], y};
        q_s.push_back(x - y);
        q_c.push_back(x >= y);
      end else begin
        u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        sg = {x[W-1], x} + {y[W-1], y} + {{W{1'b0}}, ci};
        q_s.push_back(u[W-1:0]);
        q_c.push_back(u[W]);
      end
      q_v.push_back(sg[W] != sg[W-1]);
      q_t.push_back(t);
    endfunction

    function automatic logic [W-1:0] rnd();
      logic [W-1:0] r;
      r = '0;
      case ($urandom_range(0, 7))
        0: r = '1;
        1: r = '0;
        2: r[W-1] = 1'b1;
        3: begin r = '1; r[W-1] = 1'b0; end
        default: for (int j = 0; j < int'(W); j += 32) r = (r << 32) | W'($urandom);
      endcase
      return r;
    endfunction

    always @(negedge clk) begin
      if (done) begin
        chk(gi, "done_width", 512'(prev_done), 512'(0));
        chk(gi, "busy_in_done", 512'(busy), 512'(1));
        chk(gi, "done_expected", 512'(q_s.size() > 0), 512'(1));
        if (q_s.size() > 0) begin
          chk(gi, "S", 512'(s), 512'(q_s.pop_front()));
          chk(gi, "carry", 512'(carry), 512'(q_c.pop_front()));
          chk(gi, "overflow", 512'(overflow), 512'(q_v.pop_front()));
          chk(gi, "latency", 512'(cyc), 512'(q_t.pop_front()));
        end
      end
      prev_done <= done;
    end

    task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < int'(2 * N + 8)) begin
        @(negedge clk);
        n++;
      end
      chk(gi, "idle_timeout", 512'(busy), 512'(0));
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb,
                         input logic ci, input bit track);
      wait_idle();
      start = 1'b1;
      a     = x;
      b     = y;
      sub   = sb;
      cin   = ci;
      if (track) push(x, y, sb, ci, cyc + 1 + int'(N));
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = rnd();
      b     = rnd();
      sub   = 1'($urandom_range(0, 1));
      cin   = 1'($urandom_range(0, 1));
    endtask

    task automatic span(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb,
                        input logic ci);
      int n;
      n = 0;
      issue(x, y, sb, ci, 1'b1);
      @(negedge clk);
      while (busy && n < int'(2 * N + 8)) begin
        n++;
        @(negedge clk);
      end
      chk(gi, "busy_span", 512'(n), 512'(N + 1));
    endtask

    initial begin : drv
      logic [W-1:0] ones, msb, x, y;
      logic         sb, ci;
      int           k, n;
      ones   = '1;
      msb    = '0;
      msb[W-1] = 1'b1;
      rst_n  = 1'b0;
      start  = 1'b0;
      sub    = 1'b0;
      cin    = 1'b0;
      a      = '0;
      b      = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk(gi, "rst_S", 512'(s), 512'(0));
      chk(gi, "rst_carry", 512'(carry), 512'(0));
      chk(gi, "rst_overflow", 512'(overflow), 512'(0));
      chk(gi, "rst_busy", 512'(busy), 512'(0));
      chk(gi, "rst_done", 512'(done), 512'(0));

      span(ones, '0, 1'b0, 1'b1);
      span(W'(5), W'(7), 1'b1, 1'b0);
      issue(W'(7), W'(5), 1'b1, 1'b1, 1'b1);
      issue(W'(8'h7F), W'(1), 1'b0, 1'b0, 1'b1);
      issue(W'(8'h80), W'(8'h80), 1'b0, 1'b0, 1'b1);
      issue(ones >> 1, W'(1), 1'b0, 1'b0, 1'b1);

      // Start pulses during RUN and during DONE must not launch an operation.
      issue(rnd(), rnd(), 1'b0, 1'b1, 1'b1);
      k = (N < 3) ? int'(N) : 3;
      repeat (k - 1) @(posedge clk);
      #1 start = 1'b1;
      a = rnd();
      b = rnd();
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (!done && n < int'(2 * N + 8)) begin
        @(negedge clk);
        n++;
      end
      chk(gi, "done_seen", 512'(done), 512'(1));
      start = 1'b1;
      a = rnd();
      b = rnd();
      @(posedge clk);
      #1 start = 1'b0;

      // Start held high: second op accepted in the IDLE cycle after DONE.
      wait_idle();
      x  = rnd();
      y  = rnd();
      sb = 1'($urandom_range(0, 1));
      ci = 1'($urandom_range(0, 1));
      start = 1'b1;
      a   = x;
      b   = y;
      sub = sb;
      cin = ci;
      push(x, y, sb, ci, cyc + 1 + int'(N));
      push(x, y, sb, ci, cyc + 1 + int'(N) + int'(N) + 2);
      repeat (N + 3) @(posedge clk);
      #1 start = 1'b0;

      // Mid-run reset aborts without a done pulse and clears the held result.
      issue(msb, msb | W'(1), 1'b0, 1'b0, 1'b1);
      issue(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      k = (N < 6) ? int'(N) : 6;
      repeat (k - 1) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk(gi, "abort_busy", 512'(busy), 512'(0));
      chk(gi, "abort_S", 512'(s), 512'(0));
      chk(gi, "abort_carry", 512'(carry), 512'(0));
      chk(gi, "abort_overflow", 512'(overflow), 512'(0));
      chk(gi, "abort_done", 512'(done), 512'(0));
      repeat (N + 2) @(negedge clk);

      for (int i = 0; i < int'(NOPS); i++) begin
        issue(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      n = 0;
      while (q_s.size() != 0 && n < int'(2 * N + 8)) begin
        @(negedge clk);
        n++;
      end
      chk(gi, "drain", 512'(q_s.size()), 512'(0));
      n_fin++;
    end
  end

  initial begin : main
    int guard;
    guard = 0;
    while (n_fin < NCFG && guard < 200000) begin
      @(posedge clk);
      guard++;
    end
    if (n_fin < NCFG) begin
      total++;
      bad++;
      $display("FAIL global_timeout: finished %0d of %0d configurations", n_fin, NCFG);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
